ru_fault_capture: RTL and testbench

RU_FAULT_CAPTURE -- requirements
Module: ru_fault_capture

---
 rtl/ru_fault_capture_if.sv | 31 +++
 rtl/ru_fault_capture.sv | 191 +++++++++++++++++++
 tb/tb_ru_fault_capture.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ru_fault_capture_if.sv
// ru_fault_capture_if: PE output stream plus recompute-buffer write port.
//   PE stream   : in_valid, in_ready, in_last, in_row[ROWS], in_col[COLS], in_data[WORD_SIZE]
//   buffer write: buf_we, buf_row[ROWS], buf_col[COLS], buf_data[WORD_SIZE]
// master = PE side / buffer consumer, slave = ru_fault_capture.
interface ru_fault_capture_if #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned WORD_SIZE = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [ROWS-1:0]      in_row;
    logic [COLS-1:0]      in_col;
    logic [WORD_SIZE-1:0] in_data;

    logic                 buf_we;
    logic [ROWS-1:0]      buf_row;
    logic [COLS-1:0]      buf_col;
    logic [WORD_SIZE-1:0] buf_data;

    modport master (
        output in_valid, in_last, in_row, in_col, in_data,
        input  in_ready, buf_we, buf_row, buf_col, buf_data
    );

    modport slave (
        input  in_valid, in_last, in_row, in_col, in_data,
        output in_ready, buf_we, buf_row, buf_col, buf_data
    );
endinterface

// File: rtl/ru_fault_capture.sv
// ru_fault_capture: captures PE output beats whose (row, col) matches a valid
// fault-table entry and forwards them to the recompute data buffer.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   fault_load/idx/row/col   : fault-table write (IDLE only, range-checked)
//   clear_faults             : invalidate all entries (IDLE only, load wins)
//   start / done             : pass start pulse / one-cycle completion pulse
//   pe (slave)               : PE beat stream in, buffer write port out
//   hit_vec                  : per-entry "captured this pass" flags
//   hit_count                : buffer-write counter, present only with
//                              RU_FAULT_CAPTURE_STATS_EN defined
module ru_fault_capture #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned NUM_RU    = 4,
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fault_load,
    input  logic [$clog2(NUM_RU)-1:0] fault_idx,
    input  logic [ROWS-1:0]           fault_row,
    input  logic [COLS-1:0]           fault_col,
    input  logic                      clear_faults,
    input  logic                      start,
    output logic                      done,
    ru_fault_capture_if.slave         pe,
    output logic [NUM_RU-1:0]         hit_vec
`ifdef RU_FAULT_CAPTURE_STATS_EN
    ,
    output logic [15:0]               hit_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_RU);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_RU-1:0]    tbl_valid_q, tbl_valid_d;
    logic [ROWS-1:0]      tbl_row_q [NUM_RU];
    logic [ROWS-1:0]      tbl_row_d [NUM_RU];
    logic [COLS-1:0]      tbl_col_q [NUM_RU];
    logic [COLS-1:0]      tbl_col_d [NUM_RU];
    logic                 in_ready_q, in_ready_d;
    logic                 done_q, done_d;
    logic                 buf_we_q, buf_we_d;
    logic [ROWS-1:0]      buf_row_q, buf_row_d;
    logic [COLS-1:0]      buf_col_q, buf_col_d;
    logic [WORD_SIZE-1:0] buf_data_q, buf_data_d;
    logic [NUM_RU-1:0]    hit_vec_q, hit_vec_d;
`ifdef RU_FAULT_CAPTURE_STATS_EN
    logic [15:0]          hit_count_q, hit_count_d;
`endif

    logic                 accept;
    logic                 load_ok;
    logic                 hit_any;
    logic [IDX_W-1:0]     hit_idx;

    // Next-state, fault-table update and capture datapath.
    always_comb begin
        state_d     = state_q;
        tbl_valid_d = tbl_valid_q;
        tbl_row_d   = tbl_row_q;
        tbl_col_d   = tbl_col_q;
        buf_we_d    = 1'b0;
        buf_row_d   = buf_row_q;
        buf_col_d   = buf_col_q;
        buf_data_d  = buf_data_q;
        hit_vec_d   = hit_vec_q;
`ifdef RU_FAULT_CAPTURE_STATS_EN
        hit_count_d = hit_count_q;
`endif
        accept  = pe.in_valid && in_ready_q;
        load_ok = fault_load
                  && (fault_row < ROWS'(ROWS))
                  && (fault_col < COLS'(COLS))
                  && ({1'b0, fault_idx} < (IDX_W+1)'(NUM_RU));

        // Descending scan so the lowest matching index is the one kept.
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_RU - 1; i >= 0; i--) begin
            if (tbl_valid_q[i] && (tbl_row_q[i] == pe.in_row) && (tbl_col_q[i] == pe.in_col)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (clear_faults) begin
                    tbl_valid_d = '0;
                end
                if (load_ok) begin
                    tbl_valid_d[fault_idx] = 1'b1;
                    tbl_row_d[fault_idx]   = fault_row;
                    tbl_col_d[fault_idx]   = fault_col;
                end
                if (start) begin
                    state_d     = CAPTURE;
                    hit_vec_d   = '0;
`ifdef RU_FAULT_CAPTURE_STATS_EN
                    hit_count_d = 16'd0;
`endif
                end
            end
            CAPTURE: begin
                if (accept) begin
                    if (hit_any) begin
                        buf_we_d           = 1'b1;
                        buf_row_d          = pe.in_row;
                        buf_col_d          = pe.in_col;
                        buf_data_d         = pe.in_data;
                        hit_vec_d[hit_idx] = 1'b1;
`ifdef RU_FAULT_CAPTURE_STATS_EN
                        if (hit_count_q != 16'hFFFF) begin
                            hit_count_d = hit_count_q + 16'd1;
                        end
`endif
                    end
                    if (pe.in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs registered alongside the state they decode.
        in_ready_d = (state_d == CAPTURE);
        done_d     = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tbl_valid_q <= '0;
            tbl_row_q   <= '{default: '0};
            tbl_col_q   <= '{default: '0};
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_row_q   <= '0;
            buf_col_q   <= '0;
            buf_data_q  <= '0;
            hit_vec_q   <= '0;
`ifdef RU_FAULT_CAPTURE_STATS_EN
            hit_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_row_q   <= tbl_row_d;
            tbl_col_q   <= tbl_col_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
            buf_we_q    <= buf_we_d;
            buf_row_q   <= buf_row_d;
            buf_col_q   <= buf_col_d;
            buf_data_q  <= buf_data_d;
            hit_vec_q   <= hit_vec_d;
`ifdef RU_FAULT_CAPTURE_STATS_EN
            hit_count_q <= hit_count_d;
`endif
        end
    end

    assign pe.in_ready = in_ready_q;
    assign pe.buf_we   = buf_we_q;
    assign pe.buf_row  = buf_row_q;
    assign pe.buf_col  = buf_col_q;
    assign pe.buf_data = buf_data_q;
    assign done        = done_q;
    assign hit_vec     = hit_vec_q;
`ifdef RU_FAULT_CAPTURE_STATS_EN
    assign hit_count   = hit_count_q;
`endif

endmodule

// File: tb/tb_ru_fault_capture.sv
// tb_ru_fault_capture: directed self-checking bench for ru_fault_capture.
module tb_ru_fault_capture;

    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 4;
    localparam int unsigned NUM_RU    = 4;
    localparam int unsigned WORD_SIZE = 16;

    logic        clk;
    logic        rst;
    logic        fault_load;
    logic [1:0]  fault_idx;
    logic [3:0]  fault_row;
    logic [3:0]  fault_col;
    logic        clear_faults;
    logic        start;
    logic        done;
    logic [3:0]  hit_vec;
`ifdef RU_FAULT_CAPTURE_STATS_EN
    logic [15:0] hit_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ru_fault_capture_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD_SIZE)) pe_if ();

    ru_fault_capture #(
        .ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU), .WORD_SIZE(WORD_SIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fault_load   (fault_load),
        .fault_idx    (fault_idx),
        .fault_row    (fault_row),
        .fault_col    (fault_col),
        .clear_faults (clear_faults),
        .start        (start),
        .done         (done),
        .pe           (pe_if.slave),
        .hit_vec      (hit_vec)
`ifdef RU_FAULT_CAPTURE_STATS_EN
        ,
        .hit_count    (hit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int r, input int c, input logic clr);
        fault_load   = 1'b1;
        fault_idx    = 2'(idx);
        fault_row    = 4'(r);
        fault_col    = 4'(c);
        clear_faults = clr;
        tick();
        fault_load   = 1'b0;
        clear_faults = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input int r, input int c, input logic [15:0] d, input logic last);
        pe_if.in_valid = 1'b1;
        pe_if.in_row   = 4'(r);
        pe_if.in_col   = 4'(c);
        pe_if.in_data  = d;
        pe_if.in_last  = last;
        tick();
        pe_if.in_valid = 1'b0;
        pe_if.in_last  = 1'b0;
    endtask

    // Full 16-beat raster pass; (er, ec) is the only beat expected to hit, -1 for none.
    task automatic run_raster(input int er, input int ec);
        int n_we;
        n_we = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [15:0] d;
                logic        exp_we;
                d      = 16'(32'h0100 + 4 * r + c);
                exp_we = (r == er) && (c == ec);
                beat(r, c, d, (r == 3) && (c == 3));
                if (pe_if.buf_we) n_we++;
                if (exp_we) begin
                    chk("raster_hit_we",   32'(pe_if.buf_we),   32'h1);
                    chk("raster_hit_data", 32'(pe_if.buf_data), 32'(d));
                end
            end
        end
        chk("raster_we_count", 32'(n_we), (er >= 0) ? 32'h1 : 32'h0);
        chk("raster_done",     32'(done), 32'h1);
        chk("raster_rdy_done", 32'(pe_if.in_ready), 32'h0);
        tick();
        chk("raster_done_1cyc", 32'(done), 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        fault_load     = 1'b0;
        fault_idx      = '0;
        fault_row      = '0;
        fault_col      = '0;
        clear_faults   = 1'b0;
        start          = 1'b0;
        pe_if.in_valid = 1'b0;
        pe_if.in_last  = 1'b0;
        pe_if.in_row   = '0;
        pe_if.in_col   = '0;
        pe_if.in_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready",   32'(pe_if.in_ready), 32'h0);
        chk("rst_done",    32'(done),           32'h0);
        chk("rst_we",      32'(pe_if.buf_we),   32'h0);
        chk("rst_data",    32'(pe_if.buf_data), 32'h0);
        chk("rst_hit_vec", 32'(hit_vec),        32'h0);

        // Single fault (1,2) over a raster pass
        load(0, 1, 2, 1'b0);
        do_start();
        chk("p1_ready", 32'(pe_if.in_ready), 32'h1);
        chk("p1_hitvec_clr", 32'(hit_vec), 32'h0);
        run_raster(1, 2);
        chk("p1_hit_vec", 32'(hit_vec),        32'h1);
        chk("p1_row",     32'(pe_if.buf_row),  32'h1);
        chk("p1_col",     32'(pe_if.buf_col),  32'h2);
        chk("p1_data",    32'(pe_if.buf_data), 32'h0106);

        // Duplicates (entries 1,3 = (0,0)), repeated hit, second entry hit
        load(1, 0, 0, 1'b0);
        load(3, 0, 0, 1'b0);
        do_start();
        chk("p2_hitvec_clr", 32'(hit_vec), 32'h0);
        beat(0, 0, 16'hBEEF, 1'b0);
        chk("dup_we",     32'(pe_if.buf_we),   32'h1);
        chk("dup_data",   32'(pe_if.buf_data), 32'hBEEF);
        chk("dup_hitvec", 32'(hit_vec),        32'h2);
        beat(0, 0, 16'hCAFE, 1'b0);
        chk("rep_we",     32'(pe_if.buf_we),   32'h1);
        chk("rep_data",   32'(pe_if.buf_data), 32'hCAFE);
        chk("rep_hitvec", 32'(hit_vec),        32'h2);
        beat(1, 2, 16'h1234, 1'b0);
        chk("e0_we",     32'(pe_if.buf_we), 32'h1);
        chk("e0_hitvec", 32'(hit_vec),      32'h3);
        beat(3, 0, 16'h5555, 1'b1);
        chk("miss_we",   32'(pe_if.buf_we),   32'h0);
        chk("miss_hold", 32'(pe_if.buf_data), 32'h1234);
        chk("miss_row",  32'(pe_if.buf_row),  32'h1);
        chk("p2_done",   32'(done),           32'h1);
`ifdef RU_FAULT_CAPTURE_STATS_EN
        chk("stats_count3", 32'(hit_count), 32'h3);
`endif
        tick();

        // Clear, then out-of-range loads are discarded -> no hits at all
        clear_faults = 1'b1;
        tick();
        clear_faults = 1'b0;
        load(2, 4, 0, 1'b0);
        load(0, 0, 4, 1'b0);
        do_start();
`ifdef RU_FAULT_CAPTURE_STATS_EN
        chk("stats_start_clr", 32'(hit_count), 32'h0);
`endif
        run_raster(-1, -1);
        chk("p3_hit_vec", 32'(hit_vec), 32'h0);

        // clear_faults with same-cycle load: load wins; hit on the last beat
        load(1, 3, 3, 1'b1);
        do_start();
        run_raster(3, 3);
        chk("p4_hit_vec", 32'(hit_vec), 32'h2);

        // Load during CAPTURE and start during DONE are ignored
        do_start();
        fault_load = 1'b1;
        fault_idx  = 2'd0;
        fault_row  = 4'd0;
        fault_col  = 4'd1;
        tick();
        fault_load = 1'b0;
        beat(0, 1, 16'h0055, 1'b1);
        chk("capload_we",   32'(pe_if.buf_we), 32'h0);
        chk("capload_done", 32'(done),         32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("dstart_done",  32'(done),           32'h0);
        chk("dstart_ready", 32'(pe_if.in_ready), 32'h0);
        tick();
        chk("dstart_idle",  32'(pe_if.in_ready), 32'h0);
        do_start();
        beat(3, 3, 16'h0077, 1'b1);
        chk("tbl_kept_we",   32'(pe_if.buf_we),   32'h1);
        chk("tbl_kept_data", 32'(pe_if.buf_data), 32'h0077);
        chk("tbl_kept_e0",   32'(hit_vec),        32'h2);
        tick();

        // Beat outside CAPTURE has no effect
        pe_if.in_valid = 1'b1;
        pe_if.in_row   = 4'd3;
        pe_if.in_col   = 4'd3;
        pe_if.in_data  = 16'h0099;
        tick();
        pe_if.in_valid = 1'b0;
        chk("idle_beat_we",   32'(pe_if.buf_we),   32'h0);
        chk("idle_beat_data", 32'(pe_if.buf_data), 32'h0077);
        chk("idle_beat_hv",   32'(hit_vec),        32'h2);

        // Reset during a matching accepted beat aborts the pass
        do_start();
        pe_if.in_valid = 1'b1;
        pe_if.in_row   = 4'd3;
        pe_if.in_col   = 4'd3;
        pe_if.in_data  = 16'h00AA;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pe_if.in_valid = 1'b0;
        chk("abort_we",    32'(pe_if.buf_we),   32'h0);
        chk("abort_ready", 32'(pe_if.in_ready), 32'h0);
        chk("abort_done",  32'(done),           32'h0);
        chk("abort_data",  32'(pe_if.buf_data), 32'h0);
`ifdef RU_FAULT_CAPTURE_STATS_EN
        chk("abort_count", 32'(hit_count), 32'h0);
`endif
        tick();
        chk("abort_nodone", 32'(done), 32'h0);
        do_start();
        beat(3, 3, 16'h00BB, 1'b1);
        chk("abort_tbl_we",   32'(pe_if.buf_we), 32'h0);
        chk("abort_tbl_done", 32'(done),         32'h1);
        chk("abort_tbl_hv",   32'(hit_vec),      32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
